// File: rtl/hazard_pkg.sv
// Shared definitions for the ID-stage hazard scoreboard: issue classes and register addressing.
package hazard_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  localparam logic [1:0] CLASS_ALU    = 2'd0;
  localparam logic [1:0] CLASS_LOAD   = 2'd1;
  localparam logic [1:0] CLASS_MULDIV = 2'd2;
  localparam logic [1:0] CLASS_RSVD   = 2'd3;

  // x0 is hardwired zero, so it never takes part in a register match
  function automatic logic reg_hit(input logic [REG_ADDR_W-1:0] a,
                                   input logic [REG_ADDR_W-1:0] b);
    return (a != '0) && (a == b);
  endfunction

endpackage

// File: rtl/sb_busy_table.sv
// Busy bits for x1..x31 with one set port, one clear port, two source read ports and a WAW read port.
module sb_busy_table
  import hazard_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_set_en,
  input  logic [REG_ADDR_W-1:0] i_set_addr,
  input  logic                  i_clr_en,
  input  logic [REG_ADDR_W-1:0] i_clr_addr,
  input  logic [REG_ADDR_W-1:0] i_rd1_addr,
  input  logic [REG_ADDR_W-1:0] i_rd2_addr,
  input  logic [REG_ADDR_W-1:0] i_waw_addr,
  output logic                  o_rd1_busy,
  output logic                  o_rd2_busy,
  output logic                  o_waw_busy,
  output logic [NUM_REGS-1:0]   o_busy_vec
);

  logic [NUM_REGS-1:1] r_busy;
  logic [NUM_REGS-1:0] w_vec;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (i_set_en && i_set_addr == REG_ADDR_W'(i))
          r_busy[i] <= 1'b1;
        else if (i_clr_en && i_clr_addr == REG_ADDR_W'(i))
          r_busy[i] <= 1'b0;
      end
    end
  end

  assign w_vec      = {r_busy, 1'b0};
  assign o_busy_vec = w_vec;
  assign o_rd1_busy = w_vec[i_rd1_addr];
  assign o_rd2_busy = w_vec[i_rd2_addr];
  assign o_waw_busy = w_vec[i_waw_addr];

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: load-use, MULDIV RAW/WAW and structural stalls.
// Optional macro SCOREBOARD_STATS_EN adds the saturating stall_cycles counter port.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic [1:0]            issue_class,
  input  logic                  issue_regwrite,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic [REG_ADDR_W-1:0] rs1_id,
  input  logic [REG_ADDR_W-1:0] rs2_id,
  input  logic                  use_rs1,
  input  logic                  use_rs2,
  input  logic                  cmpl_valid,
  input  logic [REG_ADDR_W-1:0] cmpl_rd,
  input  logic                  flush,
  output logic                  stall_id,
  output logic [NUM_REGS-1:0]   busy_vec,
  output logic [2:0]            outstanding,
  output logic                  sb_error
`ifdef SCOREBOARD_STATS_EN
  ,
  output logic [31:0]           stall_cycles
`endif
);

  localparam logic [2:0] MAX_C = 3'(MAX_OUTSTANDING);

  logic                  r_load_vld_q;
  logic [REG_ADDR_W-1:0] r_load_rd_q;
  logic [2:0]            r_outstanding;
  logic                  r_sb_error;

  logic                  w_rs1_busy, w_rs2_busy, w_waw_busy;
  logic [NUM_REGS-1:0]   w_busy_vec;
  logic                  w_raw1, w_raw2, w_waw, w_struct;
  logic                  w_fire, w_inc, w_set_en, w_cmpl_hit, w_load_set;

  sb_busy_table u_busy (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_set_en   (w_set_en),
    .i_set_addr (issue_rd),
    .i_clr_en   (w_cmpl_hit),
    .i_clr_addr (cmpl_rd),
    .i_rd1_addr (rs1_id),
    .i_rd2_addr (rs2_id),
    .i_waw_addr (issue_rd),
    .o_rd1_busy (w_rs1_busy),
    .o_rd2_busy (w_rs2_busy),
    .o_waw_busy (w_waw_busy),
    .o_busy_vec (w_busy_vec)
  );

  always_comb begin
    w_raw1   = use_rs1 && ((r_load_vld_q && reg_hit(rs1_id, r_load_rd_q)) || w_rs1_busy);
    w_raw2   = use_rs2 && ((r_load_vld_q && reg_hit(rs2_id, r_load_rd_q)) || w_rs2_busy);
    w_waw    = issue_regwrite && (issue_rd != '0) && w_waw_busy;
    w_struct = (issue_class == CLASS_MULDIV) && (r_outstanding == MAX_C);
    stall_id = issue_valid && (w_raw1 || w_raw2 || w_waw || w_struct);
  end

  assign w_fire     = issue_valid && !stall_id;
  assign w_inc      = w_fire && (issue_class == CLASS_MULDIV);
  assign w_set_en   = w_inc && issue_regwrite && (issue_rd != '0);
  assign w_cmpl_hit = cmpl_valid && (cmpl_rd != '0) && w_busy_vec[cmpl_rd];
  assign w_load_set = w_fire && (issue_class == CLASS_LOAD) && issue_regwrite && (issue_rd != '0);

  // flush squashes the just-issued load, so it wins over a same-cycle load set
  always_ff @(posedge clk) begin
    if (rst) begin
      r_load_vld_q <= 1'b0;
      r_load_rd_q  <= '0;
    end else begin
      r_load_vld_q <= w_load_set && !flush;
      if (w_load_set)
        r_load_rd_q <= issue_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_outstanding <= '0;
      r_sb_error    <= 1'b0;
    end else begin
      if (w_inc && !cmpl_valid && r_outstanding != MAX_C)
        r_outstanding <= r_outstanding + 3'd1;
      else if (!w_inc && cmpl_valid && r_outstanding != '0)
        r_outstanding <= r_outstanding - 3'd1;
      if (cmpl_valid && (!w_cmpl_hit || (!w_inc && r_outstanding == '0)))
        r_sb_error <= 1'b1;
    end
  end

  assign busy_vec    = w_busy_vec;
  assign outstanding = r_outstanding;
  assign sb_error    = r_sb_error;

`ifdef SCOREBOARD_STATS_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk) begin
    if (rst)
      r_stall_cycles <= '0;
    else if (issue_valid && stall_id && r_stall_cycles != '1)
      r_stall_cycles <= r_stall_cycles + 32'd1;
  end

  assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter MAX_OUTSTANDING, default 2: maximum in-flight multi-cycle (MULDIV) operations, range 1..7.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 issue_valid  input  1  ID-stage instruction is presented for issue.
REQ-005 issue_class  input  2  0=ALU, 1=LOAD, 2=MULDIV, 3=reserved (treated as ALU).
REQ-006 issue_regwrite  input  1  the issuing instruction writes rd.
REQ-007 issue_rd  input  5  destination register of the issuing instruction.
REQ-008 rs1_id, rs2_id  input  5 each  ID-stage source registers.
REQ-009 use_rs1, use_rs2  input  1 each  the source is actually read.
REQ-010 cmpl_valid  input  1  MULDIV unit writes back this cycle.
REQ-011 cmpl_rd  input  5  register written by that completion.
REQ-012 flush  input  1  branch/jump squash of the instruction currently in ID->EX.
REQ-013 stall_id  output  1  combinational; hold PC/IF-ID, inject bubble into EX.
REQ-014 busy_vec  output  32  registered busy bits; bit 0 always 0.
REQ-015 outstanding  output  3  registered count of in-flight MULDIV operations.
REQ-016 sb_error  output  1  sticky: completion arrived for a non-busy register.

Function
REQ-017 Issue fires when issue_valid && !stall_id; it is the only event that updates issue-side state.
REQ-018 Load-use: on a fired LOAD with issue_regwrite and issue_rd!=0, load_rd_q<=issue_rd and load_vld_q<=1 for exactly one cycle; otherwise load_vld_q<=0.
REQ-019 RAW stall: stall_id=1 when a used rsN != 0 matches load_rd_q while load_vld_q is set, or busy_vec[rsN] is set.
REQ-020 WAW stall: stall_id=1 when issue_regwrite and issue_rd!=0 and busy_vec[issue_rd] is set.
REQ-021 Structural stall: stall_id=1 when a MULDIV is presented and outstanding==MAX_OUTSTANDING.
REQ-022 stall_id=0 whenever issue_valid=0.
REQ-023 A fired MULDIV with issue_regwrite and rd!=0 sets busy_vec[rd] next cycle; every fired MULDIV increments outstanding.
REQ-024 cmpl_valid clears busy_vec[cmpl_rd] next cycle and decrements outstanding; with no busy bit set for cmpl_rd (or cmpl_rd=0), busy_vec is unchanged and sb_error<=1.
REQ-025 Same-cycle completion and MULDIV fire: outstanding is unchanged; fire-set and completion-clear on the same rd cannot coincide, because the WAW check in REQ-020 reads registered busy_vec.
REQ-026 Completion frees its register one cycle later; a dependent instruction stalls through the completion cycle and fires in the following cycle (forwarding unit supplies WB data).
REQ-027 outstanding saturates at 0 and MAX_OUTSTANDING; an underflowing completion sets sb_error.
REQ-028 flush clears load_vld_q next cycle; busy_vec and outstanding are untouched because issued MULDIVs always complete.
REQ-029 x0 never busy and never matches any hazard check.

Reset
REQ-030 On rst: busy_vec=0, outstanding=0, load_vld_q=0, load_rd_q=0, sb_error=0; rst overrides all same-cycle events.
REQ-031 In-flight completions arriving after rst are treated as spurious (REQ-024).

Configuration
REQ-032 SCOREBOARD_STATS_EN defined: adds output stall_cycles (32), incremented each cycle issue_valid && stall_id, saturating at all-ones, reset to 0.
REQ-033 SCOREBOARD_STATS_EN undefined: port and counter absent; all other behaviour identical.

Structure
REQ-034 Shared package hazard_pkg holds the issue_class constants (CLASS_ALU, CLASS_LOAD, CLASS_MULDIV) and REG_ADDR_W=5.
REQ-035 One sub-module sb_busy_table: 31-entry busy register array with set/clear ports and two read ports plus one WAW read port.

Verification
REQ-036 LOAD rd=5 fires, next cycle ALU uses rs1=5 -> stall_id=1 one cycle, fires the cycle after.
REQ-037 MULDIV rd=7 fires, ADD uses rs2=7 -> stall until cmpl_valid rd=7; fires one cycle after completion.
REQ-038 MAX_OUTSTANDING=2, three back-to-back MULDIVs rd=1,2,3 -> third stalls until first completion; outstanding peaks at 2.
REQ-039 cmpl_valid rd=9 with busy_vec=0 -> sb_error=1, busy_vec unchanged, outstanding stays 0.
REQ-040 LOAD rd=0 then use rs1=0 -> no stall; LOAD rd=4 followed by flush -> following use of rs1=4 does not stall.
REQ-041 rst asserted with outstanding=2 and busy rd=3 -> all outputs zero next cycle; if SCOREBOARD_STATS_EN, stall_cycles=0.
